// File: rtl/complex_nr_acc_if.sv
// Handshake bundle between the complex multiplier result port, the accumulator and the sum sink.
// The slave modport is the accumulator's view; master is the surrounding producer/consumer.
interface complex_nr_acc_if #(
  parameter int RES_WIDTH = 18,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 20
);
  localparam int CNT_W = $clog2(ACC_LEN) + 1;

  logic                   res_val;
  logic                   res_ready;
  logic [2*RES_WIDTH-1:0] res_data;
  logic                   acc_val;
  logic                   acc_ready;
  logic [2*ACC_WIDTH-1:0] acc_data;
  logic [CNT_W-1:0]       acc_cnt;

  modport slave (
    input  res_val, res_data, acc_ready,
    output res_ready, acc_val, acc_data, acc_cnt
  );

  modport master (
    output res_val, res_data, acc_ready,
    input  res_ready, acc_val, acc_data, acc_cnt
  );
endinterface

// File: rtl/complex_nr_acc.sv
// Complex dot-product accumulator: sums ACC_LEN signed complex products and hands the
// sum downstream over a valid/ready handshake, one product per cycle while accumulating.
module complex_nr_acc #(
  parameter int RES_WIDTH = 18,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst,
  complex_nr_acc_if.slave  bus
);
  localparam int CNT_W = $clog2(ACC_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [RES_WIDTH-1:0] res_re, res_im;
  logic signed [ACC_WIDTH-1:0] acc_re_p1, acc_im_p1;
  logic [CNT_W-1:0]            cnt_p1;
  logic                        xfer;
  logic                        clr;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [RES_WIDTH-1:0] v);
    return {{(ACC_WIDTH-RES_WIDTH){v[RES_WIDTH-1]}}, v};
  endfunction

  // Modulo-2^ACC_WIDTH add; wrap is impossible when ACC_WIDTH >= RES_WIDTH + clog2(ACC_LEN).
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [RES_WIDTH-1:0] b
  );
    return a + sext(b);
  endfunction

  assign res_re = bus.res_data[2*RES_WIDTH-1:RES_WIDTH];
  assign res_im = bus.res_data[RES_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rstn || sw_rst) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE:  state_nxt = ACCUM;
      ACCUM: begin
        xfer = bus.res_val;
        if (xfer && cnt_p1 == LAST) state_nxt = OUT;
      end
      OUT: begin
        if (bus.acc_ready) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulation stage: registers only move on a real transfer, so res_data is never
  // sampled while res_val or res_ready is low.
  always_ff @(posedge clk) begin
    if (!rstn || sw_rst || clr) begin
      acc_re_p1 <= '0;
      acc_im_p1 <= '0;
      cnt_p1    <= '0;
    end else if (xfer) begin
      acc_re_p1 <= acc_add(acc_re_p1, res_re);
      acc_im_p1 <= acc_add(acc_im_p1, res_im);
      cnt_p1    <= cnt_p1 + 1'b1;
    end
  end

  assign bus.res_ready = (state == ACCUM);
  assign bus.acc_val   = (state == OUT);
  assign bus.acc_data  = {acc_re_p1, acc_im_p1};
  assign bus.acc_cnt   = cnt_p1;
endmodule

// File: tb/tb_complex_nr_acc.sv
// Directed bench for complex_nr_acc: stimulus pushes expected sums into a queue and an
// independent monitor pops and compares each sum the accumulator hands off.
module tb_complex_nr_acc;
  localparam int RW  = 18;
  localparam int AL  = 4;
  localparam int AW  = 20;
  localparam int CW  = $clog2(AL) + 1;
  localparam logic [2*RW-1:0] JUNK = 36'hA_BCDE_F012;

  logic clk;
  logic rstn;
  logic sw_rst;

  complex_nr_acc_if #(.RES_WIDTH(RW), .ACC_LEN(AL), .ACC_WIDTH(AW)) bus ();

  complex_nr_acc #(.RES_WIDTH(RW), .ACC_LEN(AL), .ACC_WIDTH(AW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*AW-1:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*AW-1:0] pk(input int re, input int im);
    logic [AW-1:0] r, i;
    r = re[AW-1:0];
    i = im[AW-1:0];
    return {r, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im);
    logic rdy;
    int   n;
    bus.res_val  = 1'b1;
    bus.res_data = {re[RW-1:0], im[RW-1:0]};
    n = 0;
    do begin
      rdy = bus.res_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 64'd0, 64'd1);
    bus.res_val  = 1'b0;
    bus.res_data = JUNK;
  endtask

  // Monitor: a sum leaves the block on any cycle with acc_val and acc_ready both high.
  always @(negedge clk) begin
    if (rstn && bus.acc_val && bus.acc_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_sum", 64'(bus.acc_data), 64'd0);
      end else begin
        chk("sum_data", 64'(bus.acc_data), 64'(sb_q.pop_front()));
        chk("sum_cnt", 64'(bus.acc_cnt), 64'(AL));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*AW-1:0] held;
    rstn          = 1'b0;
    sw_rst        = 1'b0;
    bus.res_val   = 1'b0;
    bus.res_data  = JUNK;
    bus.acc_ready = 1'b1;

    // T1: reset
    tick();
    tick();
    chk("rst_res_ready", 64'(bus.res_ready), 64'd0);
    chk("rst_acc_val",   64'(bus.acc_val),   64'd0);
    chk("rst_acc_data",  64'(bus.acc_data),  64'd0);
    chk("rst_acc_cnt",   64'(bus.acc_cnt),   64'd0);
    rstn = 1'b1;
    chk("idle_res_ready", 64'(bus.res_ready), 64'd0);
    tick();
    chk("accum_res_ready", 64'(bus.res_ready), 64'd1);

    // T2 + T4: back-to-back products, then backpressure on the sum
    bus.acc_ready = 1'b0;
    sb_q.push_back(pk(8, 64));
    for (int i = 0; i < AL; i++) begin
      if (i == 2) chk("t2_mid_cnt", 64'(bus.acc_cnt), 64'd2);
      send(2, 16);
    end
    chk("t2_acc_val",  64'(bus.acc_val),  64'd1);
    chk("t2_acc_data", 64'(bus.acc_data), 64'(pk(8, 64)));
    chk("t2_acc_cnt",  64'(bus.acc_cnt),  64'(AL));
    held = bus.acc_data;
    bus.res_val  = 1'b1;
    bus.res_data = {18'sd50, 18'sd50};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_val",   64'(bus.acc_val),   64'd1);
      chk("t4_hold_data",  64'(bus.acc_data),  64'(held));
      chk("t4_hold_ready", 64'(bus.res_ready), 64'd0);
    end
    bus.res_val   = 1'b0;
    bus.res_data  = JUNK;
    bus.acc_ready = 1'b1;
    tick();
    chk("t4_rel_val",   64'(bus.acc_val),   64'd0);
    chk("t4_rel_cnt",   64'(bus.acc_cnt),   64'd0);
    chk("t4_rel_data",  64'(bus.acc_data),  64'd0);
    chk("t4_rel_ready", 64'(bus.res_ready), 64'd1);

    // T3: most-negative re and most-positive im, no wrap
    sb_q.push_back({20'h80000, 20'h7FFFC});
    for (int i = 0; i < AL; i++) send(-131072, 131071);
    tick();

    // T5: gapped inputs with mixed signs
    sb_q.push_back(pk(-1, -1));
    send(-5, 7);
    repeat (3) tick();
    send(3, -9);
    repeat (3) tick();
    send(0, 0);
    repeat (3) tick();
    send(1, 1);
    tick();

    // T6: software clear mid-accumulation
    send(100, 100);
    send(100, 100);
    chk("t6_part_cnt", 64'(bus.acc_cnt), 64'd2);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("t6_clr_cnt",   64'(bus.acc_cnt),   64'd0);
    chk("t6_clr_data",  64'(bus.acc_data),  64'd0);
    chk("t6_clr_ready", 64'(bus.res_ready), 64'd0);
    sb_q.push_back(pk(4, 0));
    for (int i = 0; i < AL; i++) send(1, 0);
    tick();

    // Clear while a sum is pending: it must be dropped
    bus.acc_ready = 1'b0;
    for (int i = 0; i < AL; i++) send(7, 7);
    chk("drop_pend_val", 64'(bus.acc_val), 64'd1);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("drop_acc_val",  64'(bus.acc_val),  64'd0);
    chk("drop_acc_data", 64'(bus.acc_data), 64'd0);
    bus.acc_ready = 1'b1;

    // One more sum after the drop to show the block recovers
    sb_q.push_back(pk(-4, 12));
    for (int i = 0; i < AL; i++) send(-1, 3);
    repeat (4) tick();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
